// File: rtl/tile_board_ctrl.sv
// tile_board_ctrl: game-state engine for the falling-tile game.
// It owns the 4x8 tile board and debounces the four column keys and the
// start key. It scrolls the board once per step period and drops one new
// tile per step into a pseudo-random column. It also scores hits and
// detects game over.
//
// Ports:
//   CLK_50M              in   1   system clock
//   RST_N                in   1   asynchronous active-low reset
//   key_n                in   4   raw column buttons, active-low (bit c = column c)
//   start_n              in   1   raw start button, active-low
//   column_0..column_3   out  24  board columns; row r at bits [23-3r:21-3r], row 0 = top
//   score                out  8   hit count, saturating at 255
//   running              out  1   high while a game is in progress
//   game_over            out  1   high after a miss or a wrong key
module tile_board_ctrl #(
  parameter int unsigned STEP_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [2:0]  TILE_CODE       = 3'b111,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic [3:0]  key_n,
  input  logic        start_n,
  output logic [23:0] column_0,
  output logic [23:0] column_1,
  output logic [23:0] column_2,
  output logic [23:0] column_3,
  output logic [7:0]  score,
  output logic        running,
  output logic        game_over
);

  localparam int unsigned NCOL      = 4;
  localparam int unsigned NKEY      = 5;
  localparam int unsigned COL_W     = 24;
  localparam int unsigned CELL_W    = 3;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned TICK_W    = $clog2(STEP_CYCLES + 1);
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: bits [3:0] are the column keys, bit 4 is start.
  // ---------------------------------------------------------------------
  logic [NKEY-1:0] sync1_q, sync1_d;
  logic [NKEY-1:0] sync2_q, sync2_d;
  logic [NKEY-1:0] deb_q, deb_d;
  logic [NKEY-1:0] press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [NKEY];
  logic [DB_W-1:0] db_cnt_d [NKEY];

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // differing samples; any sample matching the current level restarts the count.
  always_comb begin
    sync1_d = {start_n, key_n};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int k = 0; k < NKEY; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
    // Press events only on the released-to-pressed transition.
    press_d = deb_q & ~deb_d;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int k = 0; k < NKEY; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int k = 0; k < NKEY; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q [NCOL];
  logic [COL_W-1:0]    col_d [NCOL];
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                running_q, running_d;
  logic                game_over_q, game_over_d;

  logic [NCOL-1:0]     key_ev;
  logic                start_ev;
  logic [NCOL-1:0]     row7_full;
  logic [NCOL-1:0]     hit;
  logic [NCOL-1:0]     row7_left;
  logic                wrong_key;
  logic                step;
  logic [2:0]          hit_cnt;
  logic [SCORE_W:0]    score_sum;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [CELL_W-1:0]   new_cell [NCOL];

  // Per-cycle hit/miss classification and derived values.
  always_comb begin
    key_ev   = press_q[NCOL-1:0];
    start_ev = press_q[NKEY-1];
    for (int c = 0; c < NCOL; c++) begin
      row7_full[c] = |col_q[c][CELL_W-1:0];
      new_cell[c]  = (lfsr_q[1:0] == 2'(c)) ? TILE_CODE : 3'b000;
    end
    hit       = key_ev & row7_full;
    wrong_key = |(key_ev & ~row7_full);
    // Cells still occupied in row 7 once this cycle's hits are removed.
    row7_left = row7_full & ~hit;
    step      = (tick_q == TICK_W'(STEP_CYCLES - 1));
    hit_cnt   = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_cnt);
    lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  // Next-state and board update.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    score_d = score_q;
    tick_d  = tick_q;
    lfsr_d  = lfsr_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_ev) begin
          for (int c = 0; c < NCOL; c++) begin
            col_d[c] = '0;
          end
          score_d = '0;
          tick_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (wrong_key) begin
          // Any key on an empty row 7 voids the whole set of presses.
          state_d = ST_OVER;
        end else begin
          for (int c = 0; c < NCOL; c++) begin
            if (hit[c]) begin
              col_d[c][CELL_W-1:0] = 3'b000;
            end
          end
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          tick_d  = step ? '0 : tick_q + TICK_W'(1);
          if (step) begin
            if (|row7_left) begin
              state_d = ST_OVER;
            end else begin
              // Row 7 is known empty here, so the shift drops nothing.
              for (int c = 0; c < NCOL; c++) begin
                col_d[c] = {new_cell[c], col_q[c][COL_W-1:CELL_W]};
              end
              lfsr_d = lfsr_next;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      tick_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        col_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      tick_q      <= tick_d;
      lfsr_q      <= lfsr_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
      for (int c = 0; c < NCOL; c++) begin
        col_q[c] <= col_d[c];
      end
    end
  end

  assign column_0  = col_q[0];
  assign column_1  = col_q[1];
  assign column_2  = col_q[2];
  assign column_3  = col_q[3];
  assign score     = score_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_tile_board_ctrl.sv
// Bench for tile_board_ctrl: a directed vector table, an async-reset
// sequence and a random phase. A cell-level game model is compared
// against the DUT on every falling clock edge.
module tb_tile_board_ctrl;

  localparam int unsigned STEP = 16;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HL   = 2 + DEB;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b1;
  logic [3:0]  key_n   = 4'hF;
  logic        start_n = 1'b1;
  logic [23:0] column_0, column_1, column_2, column_3;
  logic [7:0]  score;
  logic        running, game_over;

  tile_board_ctrl #(
    .STEP_CYCLES     (STEP),
    .DEBOUNCE_CYCLES (DEB),
    .TILE_CODE       (3'b111),
    .LFSR_SEED       (SEED)
  ) dut (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .key_n     (key_n),
    .start_n   (start_n),
    .column_0  (column_0),
    .column_1  (column_1),
    .column_2  (column_2),
    .column_3  (column_3),
    .score     (score),
    .running   (running),
    .game_over (game_over)
  );

  always #10 CLK_50M = ~CLK_50M;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: board as an array of cells, keys as raw-sample history.
  // ---------------------------------------------------------------------
  int         m_cell [4][8];
  int         m_score;
  int         m_state;   // 0 idle, 1 run, 2 over
  int         m_tick;
  logic [15:0] m_lfsr;
  logic [4:0] m_hist [HL];
  logic [4:0] m_deb;
  logic [4:0] m_pend;

  function automatic logic [23:0] m_col(input int c);
    logic [23:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[23-3*r -: 3] = 3'(m_cell[c][r]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++) m_cell[c][r] = 0;
    m_score = 0;
    m_state = 0;
    m_tick  = 0;
    m_lfsr  = SEED;
    for (int i = 0; i < HL; i++) m_hist[i] = 5'h1F;
    m_deb  = 5'h1F;
    m_pend = 5'h00;
  endfunction

  function automatic void model_step(input logic [4:0] raw);
    logic [4:0] ev;
    logic [4:0] np;
    bit wrong, miss, same;
    ev = m_pend;
    if (m_state != 1) begin
      if (ev[4]) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 8; r++) m_cell[c][r] = 0;
        m_score = 0;
        m_tick  = 0;
        m_state = 1;
      end
    end else begin
      wrong = 0;
      for (int c = 0; c < 4; c++) if (ev[c] && m_cell[c][7] == 0) wrong = 1;
      if (wrong) begin
        m_state = 2;
      end else begin
        for (int c = 0; c < 4; c++)
          if (ev[c]) begin
            m_cell[c][7] = 0;
            if (m_score < 255) m_score++;
          end
        if (m_tick == STEP - 1) begin
          m_tick = 0;
          miss = 0;
          for (int c = 0; c < 4; c++) if (m_cell[c][7] != 0) miss = 1;
          if (miss) begin
            m_state = 2;
          end else begin
            for (int c = 0; c < 4; c++) begin
              for (int r = 7; r > 0; r--) m_cell[c][r] = m_cell[c][r-1];
              m_cell[c][0] = (int'(m_lfsr[1:0]) == c) ? 7 : 0;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
          end
        end else begin
          m_tick++;
        end
      end
    end
    // Key level is accepted once the samples taken 2..HL-1 edges ago agree.
    for (int i = HL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = raw;
    np = '0;
    for (int k = 0; k < 5; k++) begin
      same = 1;
      for (int i = 3; i < HL; i++) if (m_hist[i][k] != m_hist[2][k]) same = 0;
      if (same && m_hist[2][k] != m_deb[k]) begin
        np[k]    = ~m_hist[2][k];
        m_deb[k] = m_hist[2][k];
      end
    end
    m_pend = np;
  endfunction

  always @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) model_reset();
    else        model_step({start_n, key_n});
  end

  always @(negedge CLK_50M) begin
    if (chk_on) begin
      check("model col0", 32'(column_0), 32'(m_col(0)));
      check("model col1", 32'(column_1), 32'(m_col(1)));
      check("model col2", 32'(column_2), 32'(m_col(2)));
      check("model col3", 32'(column_3), 32'(m_col(3)));
      check("model score", 32'(score), 32'(m_score));
      check("model running", 32'(running), 32'(m_state == 1));
      check("model game_over", 32'(game_over), 32'(m_state == 2));
    end
  end

  // ---------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [3:0]  key;
    logic        start;
    int          cycles;
    logic [23:0] c0, c1, c2, c3;
    logic [7:0]  sc;
    logic        run;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] k, input logic s, input int n,
                              input logic [23:0] a, input logic [23:0] b,
                              input logic [23:0] c, input logic [23:0] d,
                              input logic [7:0] sc, input logic run, input logic ov);
    vec_t v;
    v.key = k; v.start = s; v.cycles = n;
    v.c0 = a; v.c1 = b; v.c2 = c; v.c3 = d;
    v.sc = sc; v.run = run; v.ov = ov;
    vecs.push_back(v);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " col0"}, 32'(column_0), 32'h0);
    check({tag, " col1"}, 32'(column_1), 32'h0);
    check({tag, " col2"}, 32'(column_2), 32'h0);
    check({tag, " col3"}, 32'(column_3), 32'h0);
    check({tag, " score"}, 32'(score), 32'h0);
    check({tag, " running"}, 32'(running), 32'h0);
    check({tag, " game_over"}, 32'(game_over), 32'h0);
  endtask

  initial begin
    int r;
    int hold;
    logic [3:0] mask;

    // Game 1: start, scroll, hit, bounce hit, wrong key.
    add(4'hF, 0, 6,   24'h0, 24'h0, 24'h0, 24'h0, 0, 0, 0);
    add(4'hF, 0, 1,   24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 0, 3,   24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 12,  24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 1,   24'h0, 24'hE00000, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 112, 24'h000FF8, 24'hE00007, 24'h007000, 24'h1F8000, 0, 1, 0);
    add(4'hD, 1, 2,   24'h000FF8, 24'hE00007, 24'h007000, 24'h1F8000, 0, 1, 0);
    add(4'hC, 1, 2,   24'h000FF8, 24'hE00007, 24'h007000, 24'h1F8000, 0, 1, 0);
    add(4'hD, 1, 2,   24'h000FF8, 24'hE00007, 24'h007000, 24'h1F8000, 0, 1, 0);
    add(4'hC, 1, 2,   24'h000FF8, 24'hE00000, 24'h007000, 24'h1F8000, 1, 1, 0);
    add(4'hD, 1, 2,   24'h000FF8, 24'hE00000, 24'h007000, 24'h1F8000, 1, 1, 0);
    add(4'hC, 1, 2,   24'h000FF8, 24'hE00000, 24'h007000, 24'h1F8000, 1, 1, 0);
    add(4'hD, 1, 2,   24'h000FF8, 24'hE00000, 24'h007000, 24'h1F8000, 1, 1, 0);
    add(4'hC, 1, 2,   24'hE001FF, 24'h1C0000, 24'h000E00, 24'h03F000, 1, 1, 0);
    add(4'hD, 1, 2,   24'hE001FF, 24'h1C0000, 24'h000E00, 24'h03F000, 1, 1, 0);
    add(4'hC, 1, 2,   24'hE001FF, 24'h1C0000, 24'h000E00, 24'h03F000, 1, 1, 0);
    add(4'hD, 1, 2,   24'hE001FF, 24'h1C0000, 24'h000E00, 24'h03F000, 1, 1, 0);
    add(4'hC, 1, 6,   24'hE001FF, 24'h1C0000, 24'h000E00, 24'h03F000, 1, 1, 0);
    add(4'hC, 1, 1,   24'hE001F8, 24'h1C0000, 24'h000E00, 24'h03F000, 2, 1, 0);
    add(4'hC, 1, 3,   24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 1, 0);
    add(4'hF, 1, 8,   24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 1, 0);
    add(4'hD, 1, 6,   24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 1, 0);
    add(4'hD, 1, 1,   24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 0, 1);
    add(4'hD, 1, 200, 24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 0, 1);
    add(4'hF, 1, 10,  24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 0, 1);
    // Game 2: restart, then a miss.
    add(4'hF, 0, 6,   24'h1C003F, 24'h038000, 24'hE001C0, 24'h007E00, 2, 0, 1);
    add(4'hF, 0, 1,   24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 0, 3,   24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 12,  24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 1,   24'h0, 24'hE00000, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 112, 24'h0001F8, 24'hE38007, 24'h1C0E00, 24'h007000, 0, 1, 0);
    add(4'hF, 1, 15,  24'h0001F8, 24'hE38007, 24'h1C0E00, 24'h007000, 0, 1, 0);
    add(4'hF, 1, 1,   24'h0001F8, 24'hE38007, 24'h1C0E00, 24'h007000, 0, 0, 1);
    add(4'hF, 1, 50,  24'h0001F8, 24'hE38007, 24'h1C0E00, 24'h007000, 0, 0, 1);
    // Game 3: first tile lands in a different column than game 1.
    add(4'hF, 0, 7,   24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 15,  24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    add(4'hF, 1, 1,   24'hE00000, 24'h0, 24'h0, 24'h0, 0, 1, 0);

    // Reset and idle.
    #5 RST_N = 1'b0;
    repeat (3) @(negedge CLK_50M);
    check_idle("in reset");
    RST_N  = 1'b1;
    chk_on = 1'b1;
    repeat (100) @(negedge CLK_50M);
    check_idle("idle");

    foreach (vecs[i]) begin
      key_n   = vecs[i].key;
      start_n = vecs[i].start;
      repeat (vecs[i].cycles) @(negedge CLK_50M);
      check($sformatf("vec%0d col0", i), 32'(column_0), 32'(vecs[i].c0));
      check($sformatf("vec%0d col1", i), 32'(column_1), 32'(vecs[i].c1));
      check($sformatf("vec%0d col2", i), 32'(column_2), 32'(vecs[i].c2));
      check($sformatf("vec%0d col3", i), 32'(column_3), 32'(vecs[i].c3));
      check($sformatf("vec%0d score", i), 32'(score), 32'(vecs[i].sc));
      check($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].run));
      check($sformatf("vec%0d game_over", i), 32'(game_over), 32'(vecs[i].ov));
    end

    // Reset mid-game clears outputs without waiting for a clock edge.
    repeat (3) @(negedge CLK_50M);
    #3 RST_N = 1'b0;
    #1 check_idle("async reset");
    repeat (2) @(negedge CLK_50M);
    RST_N = 1'b1;
    repeat (100) @(negedge CLK_50M);
    check_idle("post reset idle");

    // Random play; the model does all the checking.
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        key_n = 4'hF;
      end else if (r < 80) begin
        mask = '0;
        for (int c = 0; c < 4; c++) mask[c] = (m_cell[c][7] != 0);
        key_n = ~mask;
      end else begin
        key_n = 4'($urandom_range(0, 15));
      end
      if (m_state != 1) start_n = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      else              start_n = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      hold = $urandom_range(3, 24);
      repeat (hold) @(negedge CLK_50M);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_board_ctrl.md
# tile_board_ctrl

Game-state engine for the falling-tile game. Owns the 4×8 tile board, debounces the four column keys and the start key, scrolls the board at a fixed step rate, and inserts one new tile per step at a pseudo-random column. It scores hits and detects game over. Its four column buses drive the VGA display controller directly downstream.

## Interface
Parameters:
- STEP_CYCLES, 25_000_000: CLK_50M cycles per scroll step (0.5 s).
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized key level must stay stable to be accepted (20 ms).
- TILE_CODE, 3'b111: cell code written for a new tile; must be nonzero.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- CLK_50M  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- key_n  in  4  raw column buttons, active-low, asynchronous; bit c = column c.
- start_n  in  1  raw start button, active-low, asynchronous.
- column_0..column_3  out  24 each  board columns; cell r (row 0 = top) at bits [23-3r:21-3r]; 3'b000 = empty.
- score  out  8  hit count, saturates at 255.
- running  out  1  high in RUN.
- game_over  out  1  high in OVER.

## Operation
- Input conditioning, per key and for start:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level updates after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - A press event is a one-cycle pulse on the debounced 1→0 transition. Release produces no event.
- States:
  - IDLE, the reset state.
  - RUN.
  - OVER.
- IDLE: board, score and tick counter held. A start event clears all columns, score and tick counter, then enters RUN.
- RUN, each cycle in order:
  - (1) Key events.
    - Column c is a hit if its key event is present and row 7 (bits [2:0]) is nonzero.
    - If any key event lands on an empty row 7, the whole set is wrong: enter OVER, clear no cells, add no score.
    - Otherwise every hit clears its row-7 cell, and score += number of hits, saturating at 255.
  - (2) Step, when tick_cnt == STEP_CYCLES-1; tick_cnt returns to 0, else it increments.
    - If any row-7 cell is nonzero after (1), it is a miss: enter OVER and do not shift.
    - Otherwise every column shifts down one row: col <= {new_cell, col[23:3]}.
    - new_cell = TILE_CODE for column lfsr[1:0], 3'b000 for the other three.
    - The LFSR then advances once: Galois, taps 16'hB400, shift right.
- OVER: board and score frozen. A start event behaves as in IDLE: clear, then RUN.
- Start events in RUN are ignored.
- The LFSR advances only on successful steps and is never reset by start, so successive games differ.

## Timing
- All outputs are registered.
- Reset values:
  - columns all 0.
  - score 0.
  - running 0.
  - game_over 0.
  - LFSR = LFSR_SEED.
  - tick_cnt 0.
  - debounced levels 1 (released).
- Key latency: raw edge to press pulse is 2 sync cycles + DEBOUNCE_CYCLES. The resulting board/score/state change is visible one cycle after the pulse.
- First step occurs STEP_CYCLES cycles after entering RUN. Tile appears in row 0 on that edge and reaches row 7 after 7 more steps; player has one full step period at row 7.
- Hit and step in the same cycle: hit applied first, so the cleared tile does not count as a miss.
- Wrong key and step in the same cycle: OVER; no shift.
- running/game_over change on the same edge as the state register.
- Reset asserted mid-game returns to IDLE immediately; all outputs go to reset values asynchronously.

## Test plan
Bench parameters: STEP_CYCLES=16, DEBOUNCE_CYCLES=4, LFSR_SEED=16'hACE1.
- Reset/idle:
  - Stimulus: assert RST_N low, release, hold 100 cycles.
  - Required: all columns 0, score 0, running=0, game_over=0, no steps.
- Start and scroll:
  - Stimulus: start_n low for 10 cycles.
  - Required: running=1 at 2+4+1 cycles after the edge.
  - Required: after 16 further cycles exactly one column has 3'b111 in bits [23:21]. That column equals seed bits[1:0] = 2'b01, so column_1 = 24'hE00000.
  - Required: after 7 more steps that tile sits in bits [2:0].
- Hit:
  - Stimulus: press the matching key while the tile is in row 7.
  - Required: the cell clears and score = 1.
  - Required: the next step does not end the game.
- Bounce:
  - Stimulus: toggle key_n every 2 cycles for 20 cycles, then hold low.
  - Required: exactly one press event and score +1 only.
- Wrong key:
  - Stimulus: press a column whose row 7 is empty.
  - Required: game_over=1, running=0, score unchanged, board frozen for 200 cycles.
- Miss and restart:
  - Stimulus: let a tile sit in row 7 through a step; then press start.
  - Required on miss: game_over=1, board not shifted.
  - Required on start: columns cleared, score 0, running=1.
  - Required: the new first tile column differs from the seed-derived column of game 1.
